// File: rtl/rs_oldest_first_if.sv
// Reservation-station port bundle: dispatch, result broadcasts, ROB head and
// the issue outputs toward the READ stage. The station uses the slave modport;
// the dispatch/back-end side uses master.
interface rs_oldest_first_if;
  localparam int unsigned TAG_W = 5;

  // control
  logic             flush;
  logic             freeze_back;

  // dispatch
  logic             disp_valid;
  logic [TAG_W-1:0] disp_Pa;
  logic [TAG_W-1:0] disp_Pb;
  logic [TAG_W-1:0] disp_Pw;
  logic             disp_rdy_a;
  logic             disp_rdy_b;
  logic [TAG_W-1:0] disp_tag_ROB;

  // result broadcasts
  logic [TAG_W-1:0] Pw_Result_add;
  logic [TAG_W-1:0] Pw_Result_mul;
  logic [TAG_W-1:0] Pw_Result_ls;
  logic             valid_Result_add;
  logic             valid_Result_mul;
  logic             valid_Result_ls;
  logic             mode_ls;

  // ROB head
  logic [TAG_W-1:0] ptr_old;

  // station outputs
  logic             full;
  logic             valid_add;
  logic [TAG_W-1:0] Pa_add;
  logic [TAG_W-1:0] Pb_add;
  logic [TAG_W-1:0] Pw_add;
  logic [TAG_W-1:0] tag_ROB_add;

  modport master (
    output flush, freeze_back,
    output disp_valid, disp_Pa, disp_Pb, disp_Pw, disp_rdy_a, disp_rdy_b, disp_tag_ROB,
    output Pw_Result_add, Pw_Result_mul, Pw_Result_ls,
    output valid_Result_add, valid_Result_mul, valid_Result_ls, mode_ls,
    output ptr_old,
    input  full, valid_add, Pa_add, Pb_add, Pw_add, tag_ROB_add
  );

  modport slave (
    input  flush, freeze_back,
    input  disp_valid, disp_Pa, disp_Pb, disp_Pw, disp_rdy_a, disp_rdy_b, disp_tag_ROB,
    input  Pw_Result_add, Pw_Result_mul, Pw_Result_ls,
    input  valid_Result_add, valid_Result_mul, valid_Result_ls, mode_ls,
    input  ptr_old,
    output full, valid_add, Pa_add, Pb_add, Pw_add, tag_ROB_add
  );
endinterface

// File: rtl/rs_oldest_first.sv
// Oldest-first reservation station for one issue port.
// Buffers renamed micro-ops, snoops the ADD/MUL/LS result broadcasts for
// operand wakeup, and each cycle issues the ready entry whose ROB tag is
// nearest the ROB head. Issue outputs are combinational from entry state.
// Optional feature macro: RS_WAKEUP_BYPASS_EN -- when defined, same-cycle
// broadcast hits count as ready during selection (back-to-back issue).
module rs_oldest_first #(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  rs_oldest_first_if.slave rs
);

  localparam int unsigned TAG_W = 5;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] pa;
    logic [TAG_W-1:0] pb;
    logic [TAG_W-1:0] pw;
    logic [TAG_W-1:0] tag;
    logic             ra;
    logic             rb;
  } entry_t;

  // A tag matches if any qualified broadcast carries it this cycle.
  function automatic logic snoop(
    input logic [TAG_W-1:0] t,
    input logic [2:0]       hit,
    input logic [TAG_W-1:0] t_add,
    input logic [TAG_W-1:0] t_mul,
    input logic [TAG_W-1:0] t_ls
  );
    return (hit[0] && (t_add == t)) ||
           (hit[1] && (t_mul == t)) ||
           (hit[2] && (t_ls  == t));
  endfunction

  logic [DEPTH-1:0] v_q;
  entry_t           ent_q [DEPTH];

  logic [2:0]       bc_hit;
  logic [DEPTH-1:0] wake_a;
  logic [DEPTH-1:0] wake_b;
  logic [DEPTH-1:0] cand;
  logic [TAG_W-1:0] age [DEPTH];
  logic [TAG_W-1:0] best_age;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] free_idx;
  logic             full_c;
  logic             accept_c;
  logic             issue_c;
  entry_t           disp_ent;

  // Qualified broadcast hits; a store broadcast carries no register result.
  assign bc_hit = {rs.valid_Result_ls && !rs.mode_ls,
                   rs.valid_Result_mul,
                   rs.valid_Result_add};

  assign full_c   = &v_q;
  assign accept_c = rs.disp_valid && !full_c && !rs.flush;
  assign issue_c  = win_found && !rs.freeze_back && !rs.flush;
  assign rs.full  = full_c;

  // Per-entry wakeup, readiness and oldest-first selection.
  always_comb begin
    wake_a    = '0;
    wake_b    = '0;
    cand      = '0;
    best_age  = '1;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake_a[i] = snoop(ent_q[i].pa, bc_hit, rs.Pw_Result_add, rs.Pw_Result_mul, rs.Pw_Result_ls);
      wake_b[i] = snoop(ent_q[i].pb, bc_hit, rs.Pw_Result_add, rs.Pw_Result_mul, rs.Pw_Result_ls);
`ifdef RS_WAKEUP_BYPASS_EN
      cand[i] = v_q[i] && (ent_q[i].ra || wake_a[i]) && (ent_q[i].rb || wake_b[i]);
`else
      cand[i] = v_q[i] && ent_q[i].ra && ent_q[i].rb;
`endif
      // Distance from the ROB head with 5-bit wrap; strict < keeps lower index on ties.
      age[i] = TAG_W'(ent_q[i].tag - rs.ptr_old);
      if (cand[i] && (!win_found || (age[i] < best_age))) begin
        win_found = 1'b1;
        best_age  = age[i];
        win_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index free slot for dispatch (only meaningful when not full).
  always_comb begin
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!v_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Incoming entry, capturing any broadcast that lands in the dispatch cycle.
  always_comb begin
    disp_ent     = '0;
    disp_ent.pa  = rs.disp_Pa;
    disp_ent.pb  = rs.disp_Pb;
    disp_ent.pw  = rs.disp_Pw;
    disp_ent.tag = rs.disp_tag_ROB;
    disp_ent.ra  = rs.disp_rdy_a ||
                   snoop(rs.disp_Pa, bc_hit, rs.Pw_Result_add, rs.Pw_Result_mul, rs.Pw_Result_ls);
    disp_ent.rb  = rs.disp_rdy_b ||
                   snoop(rs.disp_Pb, bc_hit, rs.Pw_Result_add, rs.Pw_Result_mul, rs.Pw_Result_ls);
  end

  // Issue outputs: winner's fields, all zero when nothing issues.
  always_comb begin
    rs.valid_add   = issue_c;
    rs.Pa_add      = '0;
    rs.Pb_add      = '0;
    rs.Pw_add      = '0;
    rs.tag_ROB_add = '0;
    if (issue_c) begin
      rs.Pa_add      = ent_q[win_idx].pa;
      rs.Pb_add      = ent_q[win_idx].pb;
      rs.Pw_add      = ent_q[win_idx].pw;
      rs.tag_ROB_add = ent_q[win_idx].tag;
    end
  end

  // Entry state: flush wins; otherwise wakeup, issue-clear and dispatch-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else if (rs.flush) begin
      v_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wake_a[i]) begin
          ent_q[i].ra <= 1'b1;
        end
        if (wake_b[i]) begin
          ent_q[i].rb <= 1'b1;
        end
        if (issue_c && (IDX_W'(i) == win_idx)) begin
          v_q[i] <= 1'b0;
        end
        // The issuing slot still reads as valid, so it is never chosen here.
        if (accept_c && (IDX_W'(i) == free_idx)) begin
          v_q[i]   <= 1'b1;
          ent_q[i] <= disp_ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_oldest_first.sv
// Directed bench for rs_oldest_first (DEPTH=4). Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_rs_oldest_first;

`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic       exp_v;
  logic [4:0] exp_5;

  rs_oldest_first_if rs_if ();

  rs_oldest_first #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    rs_if.flush = 0; rs_if.freeze_back = 0; rs_if.disp_valid = 0;
    rs_if.disp_Pa = 0; rs_if.disp_Pb = 0; rs_if.disp_Pw = 0;
    rs_if.disp_rdy_a = 0; rs_if.disp_rdy_b = 0; rs_if.disp_tag_ROB = 0;
    rs_if.Pw_Result_add = 0; rs_if.Pw_Result_mul = 0; rs_if.Pw_Result_ls = 0;
    rs_if.valid_Result_add = 0; rs_if.valid_Result_mul = 0; rs_if.valid_Result_ls = 0;
    rs_if.mode_ls = 0; rs_if.ptr_old = 0;
  endtask

  task automatic set_disp(input logic [4:0] pa, input logic [4:0] pb, input logic [4:0] pw,
                          input logic [4:0] tag, input logic ra, input logic rb);
    rs_if.disp_valid = 1; rs_if.disp_Pa = pa; rs_if.disp_Pb = pb; rs_if.disp_Pw = pw;
    rs_if.disp_tag_ROB = tag; rs_if.disp_rdy_a = ra; rs_if.disp_rdy_b = rb;
  endtask

  task automatic test_reset();
    rst = 0; clr_inputs();
    #1;
    n_vec++; if (rs_if.full !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b want 0", rs_if.full); end
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", rs_if.valid_add); end
    n_vec++; if ({rs_if.Pa_add, rs_if.Pb_add, rs_if.Pw_add, rs_if.tag_ROB_add} !== 20'h0) begin n_err++; $display("FAIL rst_fields got %h want 0", {rs_if.Pa_add, rs_if.Pb_add, rs_if.Pw_add, rs_if.tag_ROB_add}); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_dispatch();
    @(negedge clk); set_disp(5'd3, 5'd4, 5'd9, 5'd2, 1, 1); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL disp_early got %0b want 0", rs_if.valid_add); end
    @(negedge clk); clr_inputs(); #1;
    n_vec++; if (rs_if.valid_add !== 1'b1) begin n_err++; $display("FAIL disp_valid got %0b want 1", rs_if.valid_add); end
    n_vec++; if (rs_if.Pw_add !== 5'd9) begin n_err++; $display("FAIL disp_pw got %0d want 9", rs_if.Pw_add); end
    n_vec++; if (rs_if.tag_ROB_add !== 5'd2) begin n_err++; $display("FAIL disp_tag got %0d want 2", rs_if.tag_ROB_add); end
    n_vec++; if ({rs_if.Pa_add, rs_if.Pb_add} !== {5'd3, 5'd4}) begin n_err++; $display("FAIL disp_srcs got %0d/%0d want 3/4", rs_if.Pa_add, rs_if.Pb_add); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL disp_after got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_wrap_order();
    @(negedge clk); rs_if.freeze_back = 1; rs_if.ptr_old = 5'd30; set_disp(5'd1, 5'd1, 5'd1, 5'd1, 1, 1);
    @(negedge clk); set_disp(5'd1, 5'd1, 5'd2, 5'd31, 1, 1);
    @(negedge clk); set_disp(5'd1, 5'd1, 5'd3, 5'd5, 1, 1); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL wrap_frozen got %0b want 0", rs_if.valid_add); end
    @(negedge clk); rs_if.disp_valid = 0; rs_if.freeze_back = 0; #1;
    n_vec++; if (rs_if.full !== 1'b0) begin n_err++; $display("FAIL wrap_full got %0b want 0", rs_if.full); end
    n_vec++; if (rs_if.tag_ROB_add !== 5'd31) begin n_err++; $display("FAIL wrap_first got %0d want 31", rs_if.tag_ROB_add); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.tag_ROB_add !== 5'd1) begin n_err++; $display("FAIL wrap_second got %0d want 1", rs_if.tag_ROB_add); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.tag_ROB_add !== 5'd5) begin n_err++; $display("FAIL wrap_third got %0d want 5", rs_if.tag_ROB_add); end
    n_vec++; if (rs_if.Pw_add !== 5'd3) begin n_err++; $display("FAIL wrap_third_pw got %0d want 3", rs_if.Pw_add); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %0b want 0", rs_if.valid_add); end
    clr_inputs();
  endtask

  task automatic test_wakeup_bypass();
    @(negedge clk); set_disp(5'd2, 5'd7, 5'd10, 5'd3, 1, 0);
    @(negedge clk); clr_inputs(); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL wake_wait got %0b want 0", rs_if.valid_add); end
    @(negedge clk); rs_if.valid_Result_mul = 1; rs_if.Pw_Result_mul = 5'd7; #1;
    exp_v = BYP; exp_5 = BYP ? 5'd10 : 5'd0;
    n_vec++; if (rs_if.valid_add !== exp_v) begin n_err++; $display("FAIL wake_cycleN got %0b want %0b", rs_if.valid_add, exp_v); end
    n_vec++; if (rs_if.Pw_add !== exp_5) begin n_err++; $display("FAIL wake_cycleN_pw got %0d want %0d", rs_if.Pw_add, exp_5); end
    @(negedge clk); clr_inputs(); #1;
    exp_v = !BYP; exp_5 = BYP ? 5'd0 : 5'd10;
    n_vec++; if (rs_if.valid_add !== exp_v) begin n_err++; $display("FAIL wake_cycleN1 got %0b want %0b", rs_if.valid_add, exp_v); end
    n_vec++; if (rs_if.Pw_add !== exp_5) begin n_err++; $display("FAIL wake_cycleN1_pw got %0d want %0d", rs_if.Pw_add, exp_5); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL wake_done got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_disp_capture();
    @(negedge clk); set_disp(5'd5, 5'd6, 5'd16, 5'd7, 0, 1);
    rs_if.valid_Result_add = 1; rs_if.Pw_Result_add = 5'd5; #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL cap_early got %0b want 0", rs_if.valid_add); end
    @(negedge clk); clr_inputs(); #1;
    n_vec++; if (rs_if.valid_add !== 1'b1) begin n_err++; $display("FAIL cap_issue got %0b want 1", rs_if.valid_add); end
    n_vec++; if (rs_if.Pw_add !== 5'd16) begin n_err++; $display("FAIL cap_pw got %0d want 16", rs_if.Pw_add); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL cap_done got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_store_ignored();
    @(negedge clk); set_disp(5'd7, 5'd1, 5'd11, 5'd4, 0, 1);
    @(negedge clk); clr_inputs(); rs_if.valid_Result_ls = 1; rs_if.mode_ls = 1; rs_if.Pw_Result_ls = 5'd7; #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL store_same got %0b want 0", rs_if.valid_add); end
    @(negedge clk); clr_inputs(); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL store_next got %0b want 0", rs_if.valid_add); end
    // A load broadcast on the same tag does wake it.
    @(negedge clk); rs_if.valid_Result_ls = 1; rs_if.mode_ls = 0; rs_if.Pw_Result_ls = 5'd7; #1;
    exp_5 = BYP ? 5'd11 : 5'd0;
    n_vec++; if (rs_if.Pw_add !== exp_5) begin n_err++; $display("FAIL load_same got %0d want %0d", rs_if.Pw_add, exp_5); end
    @(negedge clk); clr_inputs(); #1;
    exp_5 = BYP ? 5'd0 : 5'd11;
    n_vec++; if (rs_if.Pw_add !== exp_5) begin n_err++; $display("FAIL load_next got %0d want %0d", rs_if.Pw_add, exp_5); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL load_done got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_multi_wake();
    @(negedge clk); set_disp(5'd25, 5'd26, 5'd19, 5'd10, 0, 0);
    @(negedge clk); set_disp(5'd27, 5'd26, 5'd20, 5'd11, 0, 0);
    @(negedge clk); clr_inputs();
    rs_if.valid_Result_add = 1; rs_if.Pw_Result_add = 5'd25;
    rs_if.valid_Result_mul = 1; rs_if.Pw_Result_mul = 5'd26;
    rs_if.valid_Result_ls  = 1; rs_if.Pw_Result_ls  = 5'd27; #1;
    exp_5 = BYP ? 5'd10 : 5'd0;
    n_vec++; if (rs_if.tag_ROB_add !== exp_5) begin n_err++; $display("FAIL multi_c0 got %0d want %0d", rs_if.tag_ROB_add, exp_5); end
    @(negedge clk); clr_inputs(); #1;
    exp_5 = BYP ? 5'd11 : 5'd10;
    n_vec++; if (rs_if.tag_ROB_add !== exp_5) begin n_err++; $display("FAIL multi_c1 got %0d want %0d", rs_if.tag_ROB_add, exp_5); end
    @(negedge clk); #1;
    exp_5 = BYP ? 5'd0 : 5'd11;
    n_vec++; if (rs_if.tag_ROB_add !== exp_5) begin n_err++; $display("FAIL multi_c2 got %0d want %0d", rs_if.tag_ROB_add, exp_5); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL multi_done got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_full_freeze();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_disp(5'(20 + i), 5'd1, 5'(12 + i), 5'(i), 0, 1); #1;
      n_vec++; if (rs_if.full !== 1'b0) begin n_err++; $display("FAIL fill_%0d got full=%0b want 0", i, rs_if.full); end
    end
    @(negedge clk); set_disp(5'd24, 5'd1, 5'd17, 5'd8, 1, 1); #1;
    n_vec++; if (rs_if.full !== 1'b1) begin n_err++; $display("FAIL full_set got %0b want 1", rs_if.full); end
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL full_noissue got %0b want 0", rs_if.valid_add); end
    @(negedge clk); clr_inputs(); rs_if.freeze_back = 1; rs_if.valid_Result_add = 1; rs_if.Pw_Result_add = 5'd21; #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL freeze_wake got %0b want 0", rs_if.valid_add); end
    @(negedge clk); rs_if.valid_Result_add = 0; #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL freeze_hold got %0b want 0", rs_if.valid_add); end
    n_vec++; if (rs_if.full !== 1'b1) begin n_err++; $display("FAIL freeze_full got %0b want 1", rs_if.full); end
    @(negedge clk); rs_if.freeze_back = 0; #1;
    n_vec++; if (rs_if.valid_add !== 1'b1) begin n_err++; $display("FAIL release_valid got %0b want 1", rs_if.valid_add); end
    n_vec++; if ({rs_if.tag_ROB_add, rs_if.Pw_add} !== {5'd1, 5'd13}) begin n_err++; $display("FAIL release_fields got tag=%0d pw=%0d want 1/13", rs_if.tag_ROB_add, rs_if.Pw_add); end
    n_vec++; if (rs_if.full !== 1'b1) begin n_err++; $display("FAIL release_full got %0b want 1", rs_if.full); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.full !== 1'b0) begin n_err++; $display("FAIL full_drop got %0b want 0", rs_if.full); end
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL dropped_disp got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_flush();
    // Three entries (PA 20, 22, 23) remain; wake all and dispatch while flushing.
    @(negedge clk); rs_if.flush = 1;
    rs_if.valid_Result_add = 1; rs_if.Pw_Result_add = 5'd20;
    rs_if.valid_Result_mul = 1; rs_if.Pw_Result_mul = 5'd22;
    rs_if.valid_Result_ls  = 1; rs_if.Pw_Result_ls  = 5'd23;
    set_disp(5'd1, 5'd1, 5'd18, 5'd9, 1, 1); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL flush_same got %0b want 0", rs_if.valid_add); end
    @(negedge clk); clr_inputs(); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL flush_next got %0b want 0", rs_if.valid_add); end
    n_vec++; if (rs_if.full !== 1'b0) begin n_err++; $display("FAIL flush_full got %0b want 0", rs_if.full); end
    @(negedge clk); #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL flush_later got %0b want 0", rs_if.valid_add); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rs_if.freeze_back = 1; set_disp(5'd1, 5'd1, 5'(21 + i), 5'(6 + i), 1, 1);
    end
    @(negedge clk); rs_if.disp_valid = 0; #1;
    n_vec++; if (rs_if.full !== 1'b1) begin n_err++; $display("FAIL ar_full got %0b want 1", rs_if.full); end
    @(negedge clk); rs_if.freeze_back = 0; #1;
    n_vec++; if (rs_if.Pw_add !== 5'd21) begin n_err++; $display("FAIL ar_pre_pw got %0d want 21", rs_if.Pw_add); end
    #2 rst = 0; #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL ar_valid got %0b want 0", rs_if.valid_add); end
    n_vec++; if (rs_if.full !== 1'b0) begin n_err++; $display("FAIL ar_full_clr got %0b want 0", rs_if.full); end
    n_vec++; if ({rs_if.Pa_add, rs_if.Pb_add, rs_if.Pw_add, rs_if.tag_ROB_add} !== 20'h0) begin n_err++; $display("FAIL ar_fields got %h want 0", {rs_if.Pa_add, rs_if.Pb_add, rs_if.Pw_add, rs_if.tag_ROB_add}); end
    @(negedge clk); rst = 1; #1;
    n_vec++; if (rs_if.valid_add !== 1'b0) begin n_err++; $display("FAIL ar_after got %0b want 0", rs_if.valid_add); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_dispatch();
    test_wrap_order();
    test_wakeup_bypass();
    test_disp_capture();
    test_store_ignored();
    test_multi_wake();
    test_full_freeze();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_oldest_first.md
# rs_oldest_first

Oldest-first reservation station for the ADD (or MUL) issue port, directly upstream of the back-end READ stage. It buffers renamed micro-ops from dispatch and tracks operand readiness by snooping the ADD/MUL/LS result broadcasts. Each cycle it issues at most one ready entry, choosing the one whose ROB tag is nearest the ROB head pointer. The chosen entry drives `valid_add`, `Pa_add`, `Pb_add`, `Pw_add` and `tag_ROB_add` into the PRF read and READ-EX register.

## Interface
- `DEPTH`, default 4: entry count, 2–8.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous; invalidates every entry.
- `freeze_back`  in  1  back-end stall; blocks issue.
- `disp_valid`  in  1  dispatch request.
- `disp_Pa`, `disp_Pb`, `disp_Pw`  in  5  physical source and destination tags.
- `disp_rdy_a`, `disp_rdy_b`  in  1  operand ready per busy table.
- `disp_tag_ROB`  in  5  allocated ROB entry.
- `Pw_Result_add`, `Pw_Result_mul`, `Pw_Result_ls`  in  5  broadcast destination tags.
- `valid_Result_add`, `valid_Result_mul`, `valid_Result_ls`  in  1  broadcast valids.
- `mode_ls`  in  1  1 = store; a store broadcast never wakes an operand.
- `ptr_old`  in  5  ROB head tag (oldest in flight).
- `full`  out  1  all entries valid.
- `valid_add`  out  1  issue valid.
- `Pa_add`, `Pb_add`, `Pw_add`, `tag_ROB_add`  out  5  issued fields.

## Operation
- Entry state: `v`, `Pa`, `Pb`, `Pw`, `tag`, `ra`, `rb`.
- Wakeup:
  - A broadcast hits when its valid is high, and for LS also when `mode_ls`=0.
  - Any hit whose tag equals `Pa` sets `ra`; any hit whose tag equals `Pb` sets `rb`.
  - Up to three hits are applied in the same cycle.
- Dispatch:
  - Accepted when `disp_valid` && !`full` && !`flush`.
  - The entry is written to the lowest-index free slot.
  - `ra` = `disp_rdy_a` OR (a same-cycle broadcast hit on `disp_Pa`); `rb` likewise.
  - Dispatch while `full` is dropped silently. Upstream must gate dispatch on `full`.
- Selection:
  - Candidates are entries with `v`&&`ra`&&`rb`.
  - Age = (`tag` − `ptr_old`) mod 32, 5-bit unsigned wrap. The smallest age wins.
  - Ties (not legal) go to the lower index.
- Issue:
  - `valid_add` = any candidate && !`freeze_back` && !`flush`.
  - Outputs carry the winner's fields. When `valid_add`=0, all output fields are 0.
  - The winner's `v` clears on the same edge.
- Flush: on the next edge every `v` clears and dispatch is ignored. Flush has priority over all other events.
- Simultaneous issue and dispatch:
  - The freed slot is not reused in the same cycle. The new entry takes another free slot.
  - `full` is computed from the current `v` only, so a full station does not accept dispatch even while issuing.

## Timing
- Reset (`rst`=0, async): all `v`=0.
  - `full`=0, `valid_add`=0.
  - `Pa_add`, `Pb_add`, `Pw_add`, `tag_ROB_add` = 0.
- Issue outputs are combinational from entry state and the current broadcast (bypass, see Configuration).
- Dispatch-to-issue latency: minimum 1 cycle. An entry written at edge N can issue in cycle N+1.
- Wakeup:
  - Broadcast in cycle N makes the operand selectable in cycle N+1.
  - With the bypass enabled it is selectable in cycle N itself.
- `full` is registered-state derived: it asserts in the cycle after the DEPTH-th entry is written.
- `freeze_back` holds all entries. Wakeups still apply during a freeze.

## Configuration
- `RS_WAKEUP_BYPASS_EN` defined:
  - The selection logic treats same-cycle broadcast hits as ready.
  - A dependent micro-op issues in the cycle its producer's result broadcasts (back-to-back).
- Undefined: selection uses only registered `ra`/`rb`, adding one cycle of wakeup-to-issue latency.
- Dispatch-time capture of same-cycle broadcasts is present in both builds.

## Test plan
- Reset and dispatch:
  - Stimulus: reset, then dispatch {Pa=3, Pb=4, Pw=9, tag=2, rdy=1,1}.
  - Required: next cycle `valid_add`=1, `Pw_add`=9, `tag_ROB_add`=2. The cycle after, `valid_add`=0.
- Oldest-first with wrap:
  - Stimulus: `ptr_old`=30; dispatch ready entries with tags 1, 31, 5.
  - Required: issue order 31, 1, 5.
- Wakeup and bypass:
  - Stimulus: entry waiting on Pb=7; `valid_Result_mul`=1, `Pw_Result_mul`=7 in cycle N.
  - Required: issues in cycle N with `RS_WAKEUP_BYPASS_EN`, in cycle N+1 without it.
- Store broadcast ignored:
  - Stimulus: `valid_Result_ls`=1, `mode_ls`=1, `Pw_Result_ls`=7.
  - Required: entry waiting on 7 stays unissued.
- Full and freeze:
  - Stimulus: dispatch DEPTH unready entries.
  - Required: `full`=1; a further dispatch is dropped.
  - Stimulus: wake one entry with `freeze_back`=1.
  - Required: `valid_add`=0. After release, it issues and `full` drops the next cycle.
- Flush and async reset:
  - Stimulus: flush with 3 valid entries.
  - Required: `valid_add`=0 and `full`=0 next cycle; no further issue.
  - Stimulus: `rst` low mid-cycle.
  - Required: outputs 0 immediately.
